// File: rtl/buf_pkg.sv
// rtl/buf_pkg.sv - shared types and constants for the buffer arbiter blocks
package buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] TUSER_PAUSE = 2'b11;
  localparam logic [1:0] TUSER_NONE  = 2'b00;

endpackage

// File: rtl/buf_rr_pick.sv
// rtl/buf_rr_pick.sv - round-robin search over memory channels 1..NCH-1
module buf_rr_pick #(
  parameter int NCH  = 2,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic            found_o,
  output logic [CH_W-1:0] idx_o
);

  always_comb begin
    int start;
    int c;
    logic [CH_W-1:0] ci;
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    ci      = '0;
    // an out-of-range pointer falls back to the first memory channel
    start   = (int'(ptr_i) >= 1 && int'(ptr_i) < NCH) ? int'(ptr_i) : 1;
    for (int k = 0; k < NCH - 1; k++) begin
      c  = ((start - 1 + k) % (NCH - 1)) + 1;
      ci = CH_W'(c);
      if (!found_o && req_i[ci]) begin
        found_o = 1'b1;
        idx_o   = ci;
      end
    end
  end

endmodule

// File: rtl/buf_arb_mon.sv
// rtl/buf_arb_mon.sv - frame-boundary arbiter of NCH buffer queues onto the XGMII TX path
module buf_arb_mon
  import buf_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int SPACE_W   = 3,
  parameter int URGENT_TH = 1,
  parameter int PAUSE_ON  = 3,
  parameter int PAUSE_OFF = 5,
  parameter int MAX_BURST = 4,
  parameter int CH_W      = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*SPACE_W-1:0] q_space,
  input  logic [NCH-1:0]         q_empty,
  input  logic                   frame_fin,
  input  logic [NCH-1:0]         flush_req,
  output logic [NCH-1:0]         q_read,
  output logic [NCH-1:0]         q_reset,
  output logic                   ipg_en,
  output logic [1:0]             tuser,
  output logic [CH_W-1:0]        grant_ch
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SPACE_W-1:0] URG_T     = SPACE_W'(URGENT_TH);
  localparam logic [SPACE_W-1:0] ON_T      = SPACE_W'(PAUSE_ON);
  localparam logic [SPACE_W-1:0] OFF_T     = SPACE_W'(PAUSE_OFF);
  localparam logic [BW-1:0]      BURST_MAX = BW'(MAX_BURST);
  localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(NCH - 1);
  localparam logic [CH_W-1:0]    FIRST_MEM = CH_W'(1);

  state_e          state_q, state_d;
  logic [NCH-1:0]  q_read_q, q_read_d;
  logic [NCH-1:0]  q_reset_q, q_reset_d;
  logic            ipg_en_q, ipg_en_d;
  logic [1:0]      tuser_q, tuser_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            pause_q, pause_d;

  logic [NCH-1:0]  avail;
  logic [NCH-1:0]  mem_req;
  logic            rr_found;
  logic [CH_W-1:0] rr_idx;
  logic            ch0_pick;
  logic            sel_valid;
  logic [CH_W-1:0] sel_ch;
  logic            any_lo, all_hi;
  logic            do_sel;

  // a channel being flushed this cycle is never a candidate
  assign avail   = ~q_empty & ~flush_req;
  assign mem_req = {avail[NCH-1:1], 1'b0};

  buf_rr_pick #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_pick (
    .req_i   (mem_req),
    .ptr_i   (rr_ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  assign ch0_pick  = avail[0] && ((q_space[SPACE_W-1:0] <= URG_T) || !rr_found ||
                                  (burst_q == BURST_MAX));
  assign sel_valid = ch0_pick || rr_found;
  assign sel_ch    = ch0_pick ? '0 : rr_idx;

  always_comb begin
    any_lo = 1'b0;
    all_hi = 1'b1;
    for (int i = 1; i < NCH; i++) begin
      if (q_space[i*SPACE_W +: SPACE_W] < ON_T)  any_lo = 1'b1;
      if (q_space[i*SPACE_W +: SPACE_W] < OFF_T) all_hi = 1'b0;
    end
    pause_d = any_lo ? 1'b1 : (all_hi ? 1'b0 : pause_q);
  end

  always_comb begin
    state_d   = state_q;
    q_read_d  = q_read_q;
    ipg_en_d  = ipg_en_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    burst_d   = burst_q;
    q_reset_d = flush_req;
    tuser_d   = pause_d ? TUSER_PAUSE : TUSER_NONE;
    do_sel    = 1'b0;

    case (state_q)
      IDLE:  do_sel = 1'b1;
      SERVE: begin
        // flushing the granted queue takes priority over a frame boundary
        if (flush_req[grant_q]) begin
          state_d  = FLUSH;
          q_read_d = '0;
          ipg_en_d = 1'b0;
        end else if (frame_fin) begin
          do_sel = 1'b1;
        end
      end
      FLUSH: begin
        state_d  = IDLE;
        q_read_d = '0;
        ipg_en_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        q_read_d = '0;
        ipg_en_d = 1'b0;
      end
    endcase

    if (do_sel) begin
      if (sel_valid) begin
        state_d  = SERVE;
        grant_d  = sel_ch;
        q_read_d = NCH'(1) << sel_ch;
        ipg_en_d = (sel_ch != '0);
        if (sel_ch == '0) begin
          burst_d = '0;
        end else begin
          rr_ptr_d = (sel_ch == LAST_CH) ? FIRST_MEM : sel_ch + FIRST_MEM;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
        end
      end else begin
        state_d  = IDLE;
        q_read_d = '0;
        ipg_en_d = 1'b0;
      end
    end

    if (q_empty[0]) burst_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      q_read_q  <= '0;
      q_reset_q <= '0;
      ipg_en_q  <= 1'b0;
      tuser_q   <= TUSER_NONE;
      grant_q   <= '0;
      rr_ptr_q  <= FIRST_MEM;
      burst_q   <= '0;
      pause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_read_q  <= q_read_d;
      q_reset_q <= q_reset_d;
      ipg_en_q  <= ipg_en_d;
      tuser_q   <= tuser_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      burst_q   <= burst_d;
      pause_q   <= pause_d;
    end
  end

  assign q_read   = q_read_q;
  assign q_reset  = q_reset_q;
  assign ipg_en   = ipg_en_q;
  assign tuser    = tuser_q;
  assign grant_ch = grant_q;

endmodule
